// File: rtl/inst_fetch.sv
// Fetch stage: issues in-order 32-bit instruction reads, buffers them in a prefetch FIFO,
// and presents one {inst, PC} per cycle to decode. Define FETCH_PERF_EN for bubble/flush counters.
module inst_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] inst,
  output logic [63:0] PC_o,
  output logic        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [63:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   inst_q;
  logic [63:0]   pc_q;
  logic          valid_q;

  logic [63:0]   rpc_al;
  logic [CW:0]   inflight;
  logic          hs, push, pop;

  assign rpc_al   = redirect_pc & ~64'h3;
  // Capacity is reserved at issue: FIFO entries plus requests still in flight.
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};

  assign imem_req_valid = reset & ~redirect & (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign hs   = imem_req_valid & imem_req_ready;
  assign push = imem_resp_valid & ~redirect & (drop_q == '0);
  assign pop  = ~redirect & ~stall & (count_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(hs) - CW'(imem_resp_valid);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (redirect) begin
      // Everything still in flight belongs to the old path and must be discarded.
      fetch_pc_d = rpc_al;
      resp_pc_d  = rpc_al;
      drop_d     = outst_d;
      count_d    = '0;
    end else begin
      if (hs) fetch_pc_d = fetch_pc_q + 64'd4;
      if (imem_resp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              resp_pc_d = resp_pc_q + 64'd4;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inst_q     <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (redirect) begin
        inst_q  <= NOP;
        valid_q <= 1'b0;
        pc_q    <= rpc_al;
      end else if (!stall) begin
        if (count_q != '0) begin
          inst_q  <= fifo_inst_q[rd_ptr_q];
          pc_q    <= fifo_pc_q[rd_ptr_q];
          valid_q <= 1'b1;
        end else begin
          inst_q  <= NOP;
          valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign inst       = inst_q;
  assign PC_o       = pc_q;
  assign inst_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubbles_q, flushes_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      if (redirect && flushes_q != '1) flushes_q <= flushes_q + 32'd1;
      if (!redirect && !stall && count_q == '0 && bubbles_q != '1)
        bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: 1-cycle memory model, in-order scoreboard of fetched
// PCs, a redirect vector table and hand-written stall / backpressure / flush sequences.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] inst;
  logic [63:0] PC_o;
  logic        inst_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  always #5 CLK = ~CLK;

  inst_fetch #(.RESET_PC(64'h1000), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .PC_o(PC_o), .inst_valid(inst_valid)
`ifdef FETCH_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct {
    logic [63:0] rpc;
    logic        with_stall;
    logic [63:0] exp_pc;
  } redir_vec_t;

  int vecs = 0;
  int errs = 0;
  logic [63:0] mem_q[$];
  logic [63:0] exp_q[$];
  int          hs_cnt = 0;
  logic [63:0] first_hs_addr = '0;
  logic [63:0] last_hs_addr = '0;
  logic        drv_ready = 1'b1, drv_stall = 1'b0, drv_redir = 1'b0, resp_en = 1'b1;
  logic [63:0] drv_rpc = '0;
  logic        stall_prev = 1'b0, redir_prev = 1'b0;
  logic [63:0] held_pc = '0;
  logic [31:0] held_inst = NOP;
  int          exp_bub = 0, exp_flush = 0;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample_hs();
    #2;
    if (imem_req_valid && imem_req_ready) begin
      if (hs_cnt == 0) first_hs_addr = imem_req_addr;
      last_hs_addr = imem_req_addr;
      mem_q.push_back(imem_req_addr);
      exp_q.push_back(imem_req_addr);
      hs_cnt++;
    end
  endtask

  task automatic check_out();
    logic [63:0] e;
    if (inst_valid) begin
      if (stall_prev) begin
        chk("hold_pc", PC_o, held_pc);
        chk("hold_inst", {32'h0, inst}, {32'h0, held_inst});
      end else if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_pc", PC_o, e);
        chk("stream_inst", {32'h0, inst}, {32'h0, mdata(e)});
      end
    end else begin
      chk("nop_inst", {32'h0, inst}, {32'h0, NOP});
    end
    if (!inst_valid && !stall_prev && !redir_prev) exp_bub++;
    held_pc   = PC_o;
    held_inst = inst;
  endtask

  task automatic step();
    logic [63:0] a;
    @(negedge CLK);
    check_out();
    if (resp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mdata(a);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    imem_req_ready = drv_ready;
    stall          = drv_stall;
    redirect       = drv_redir;
    redirect_pc    = drv_rpc;
    if (drv_redir) begin
      exp_q.delete();
      exp_flush++;
    end
    stall_prev = drv_stall;
    redir_prev = drv_redir;
    sample_hs();
  endtask

  initial begin
    redir_vec_t vt[5];
    int first_valid;
    int h0;
    logic seen;

    vt[0] = '{64'h3000, 1'b1, 64'h3000};
    vt[1] = '{64'h3001, 1'b0, 64'h3000};
    vt[2] = '{64'h4002, 1'b1, 64'h4000};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vt[4] = '{64'h80, 1'b0, 64'h80};

    reset = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (3) @(negedge CLK);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("rst_inst", {32'h0, inst}, {32'h0, NOP});
    chk("rst_pc", PC_o, 64'd0);
    chk("rst_valid", {63'h0, inst_valid}, 64'd0);

    // T1: release reset with ready=1 and a 1-cycle memory
    reset = 1'b1;
    imem_req_ready = 1'b1;
    sample_hs();
    first_valid = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (inst_valid && first_valid < 0) first_valid = i;
    end
    chk("t1_first_req_addr", first_hs_addr, 64'h1000);
    chk("t1_first_valid_cycle", 64'(first_valid), 64'd3);

    // T2: responses withheld, request window must close at FIFO_DEPTH
    drv_ready = 1'b0;
    repeat (8) step();
    resp_en = 1'b0;
    drv_ready = 1'b1;
    h0 = hs_cnt;
    repeat (10) step();
    chk("t2_handshakes", 64'(hs_cnt - h0), 64'd4);
    chk("t2_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("t2_inst_valid", {63'h0, inst_valid}, 64'd0);
    resp_en = 1'b1;
    drv_ready = 1'b0;
    repeat (8) step();

    // T3: fill FIFO under stall, then resume
    drv_ready = 1'b1;
    repeat (3) step();
    drv_stall = 1'b1;
    repeat (3) step();
    h0 = hs_cnt;
    repeat (2) step();
    chk("t3_no_req_while_full", 64'(hs_cnt - h0), 64'd0);
    chk("t3_req_valid", {63'h0, imem_req_valid}, 64'd0);
    drv_stall = 1'b0;
    repeat (10) step();

    // T4: redirect to 0x2000 with three requests outstanding
    drv_ready = 1'b0;
    repeat (8) step();
    resp_en = 1'b0;
    drv_ready = 1'b1;
    repeat (3) step();
    drv_ready = 1'b0;
    step();
    drv_redir = 1'b1;
    drv_rpc = 64'h2000;
    drv_ready = 1'b1;
    step();
    h0 = hs_cnt;
    drv_redir = 1'b0;
    resp_en = 1'b1;
    step();
    chk("t4_redir_pc", PC_o, 64'h2000);
    chk("t4_redir_valid", {63'h0, inst_valid}, 64'd0);
    chk("t4_next_req_count", 64'(hs_cnt - h0), 64'd1);
    chk("t4_next_req_addr", last_hs_addr, 64'h2000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (inst_valid && !seen) begin
        seen = 1'b1;
        chk("t4_first_valid_pc", PC_o, 64'h2000);
      end
    end
    chk("t4_saw_valid", {63'h0, seen}, 64'd1);
`ifdef FETCH_PERF_EN
    chk("t6_perf_flushes", {32'h0, perf_flushes}, 64'(exp_flush));
    chk("t6_perf_bubbles", {32'h0, perf_bubbles}, 64'(exp_bub));
`endif

    // T5 and redirect table: redirect (optionally with stall) in a running stream
    for (int v = 0; v < 5; v++) begin
      drv_ready = 1'b1;
      drv_redir = 1'b1;
      drv_stall = vt[v].with_stall;
      drv_rpc = vt[v].rpc;
      step();
      drv_redir = 1'b0;
      drv_stall = 1'b0;
      step();
      chk("redir_tbl_valid", {63'h0, inst_valid}, 64'd0);
      chk("redir_tbl_inst", {32'h0, inst}, {32'h0, NOP});
      chk("redir_tbl_pc", PC_o, vt[v].exp_pc);
      repeat (8) step();
    end

    // Back-to-back redirects: the last one wins
    drv_redir = 1'b1;
    drv_rpc = 64'h6000;
    step();
    drv_rpc = 64'h7000;
    step();
    drv_redir = 1'b0;
    step();
    chk("b2b_redir_pc", PC_o, 64'h7000);
    repeat (10) step();

    drv_ready = 1'b0;
    repeat (10) step();
    chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_EN
    chk("perf_flushes_final", {32'h0, perf_flushes}, 64'(exp_flush));
    chk("perf_bubbles_final", {32'h0, perf_bubbles}, 64'(exp_bub));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
